// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for fifo_thresh. The pointer type and
//               status struct are sized for the deepest supported FIFO
//               (N <= 65536); each instance uses only the low-order bits it
//               needs and slices them explicitly.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Widest pointer and occupancy fields. Both keep at least one spare MSB
  // above the largest per-instance width, so the unused-bit slices are never
  // empty.
  localparam int unsigned c_PTR_W_MAX = 17;
  localparam int unsigned c_LVL_W_MAX = 18;

  // Read/write pointer. It holds an index in 0..N-1.
  typedef logic [c_PTR_W_MAX-1:0] ptr_t;

  // Registered status word. All fields are derived from the next-state level.
  typedef struct packed {
    logic                   empty;
    logic                   full;
    logic [c_LVL_W_MAX-1:0] level;
    logic                   almost_full;
    logic                   almost_empty;
  } fifo_status_t;

  // Width of the occupancy and threshold fields. They must hold 0..n.
  function automatic int fifo_cw(input int n);
    return $clog2(n + 1);
  endfunction

  // Width needed to index n storage entries. It is never narrower than 1 bit.
  function automatic int fifo_pw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_wrap.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_wrap
// Description : Pointer register that counts 0..N-1. It wraps explicitly from
//               N-1 to 0, so non-power-of-2 depths never alias. A clear takes
//               priority over an increment.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output ptr_t ptr_o
);

  ptr_t ptr_q;
  ptr_t ptr_d;

  // Next pointer: a clear wins; otherwise advance, wrapping at the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == ptr_t'(N - 1)) ? '0 : ptr_q + ptr_t'(1);
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/fifo_thresh.sv
`default_nettype none
// ============================================================================
// Module      : fifo_thresh
// Description : Single-clock FIFO with arbitrary depth, occupancy count,
//               programmable almost-full/almost-empty flags, pop-frees-slot
//               push acceptance when full, and sticky overflow/underflow
//               flags. All status outputs are registered from the next level.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 16,
  parameter int CW = fifo_cw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  input  logic          flush,
  input  logic [CW-1:0] af_thresh,
  input  logic [CW-1:0] ae_thresh,
  input  logic          err_clr,
  output logic          empty_r,
  output logic          full_r,
  output logic [CW-1:0] level_r,
  output logic          almost_full_r,
  output logic          almost_empty_r,
  output logic          overflow_r,
  output logic          underflow_r
);

  localparam int PW = fifo_pw(N);

  localparam fifo_status_t c_STAT_RST = '{
    empty:        1'b1,
    full:         1'b0,
    level:        '0,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  logic          pop_adv;
  logic          push_adv;
  logic          wr_inc;
  logic          rd_inc;
  logic [CW-1:0] level_cur;
  logic [CW-1:0] level_d;
  fifo_status_t  stat_q;
  fifo_status_t  stat_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          unf_q;
  logic          unf_d;
  ptr_t          rd_ptr;
  ptr_t          wr_ptr;
  logic [W-1:0]  mem_q [N];
  logic          unused_bits;

  assign level_cur = stat_q.level[CW-1:0];

  // Advance qualifiers, next level, next status and sticky error updates.
  // A flush suppresses both pointer moves and the write. The error flags see
  // the raw requests, gated by flush.
  always_comb begin
    pop_adv  = pop & ~stat_q.empty;
    push_adv = push & (~stat_q.full | pop);
    wr_inc   = push_adv & ~flush;
    rd_inc   = pop_adv & ~flush;

    level_d  = flush ? '0 : (level_cur + CW'(push_adv) - CW'(pop_adv));

    stat_d              = c_STAT_RST;
    stat_d.empty        = (level_d == '0);
    stat_d.full         = (level_d == CW'(N));
    stat_d.level        = {{(c_LVL_W_MAX - CW){1'b0}}, level_d};
    stat_d.almost_full  = (level_d >= af_thresh);
    stat_d.almost_empty = (level_d <= ae_thresh);

    // A set takes priority over a simultaneous clear.
    ovf_d = (push & stat_q.full & ~pop & ~flush) | (ovf_q & ~err_clr);
    unf_d = (pop & stat_q.empty & ~flush) | (unf_q & ~err_clr);
  end

  // Status and error-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= c_STAT_RST;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  fifo_ptr_wrap #(.N(N)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_inc),
    .clr_i (flush),
    .ptr_o (wr_ptr)
  );

  fifo_ptr_wrap #(.N(N)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_inc),
    .clr_i (flush),
    .ptr_o (rd_ptr)
  );

  // Storage array without reset. Contents are only meaningful below the level.
  always_ff @(posedge clk) begin
    if (wr_inc) begin
      mem_q[wr_ptr[PW-1:0]] <= push_data;
    end
  end

  assign pop_data       = mem_q[rd_ptr[PW-1:0]];
  assign empty_r        = stat_q.empty;
  assign full_r         = stat_q.full;
  assign level_r        = level_cur;
  assign almost_full_r  = stat_q.almost_full;
  assign almost_empty_r = stat_q.almost_empty;
  assign overflow_r     = ovf_q;
  assign underflow_r    = unf_q;

  // The upper bits of the package-wide pointer and level fields are unused.
  assign unused_bits = ^{stat_q.level[c_LVL_W_MAX-1:CW],
                         rd_ptr[c_PTR_W_MAX-1:PW],
                         wr_ptr[c_PTR_W_MAX-1:PW]};

endmodule
`default_nettype wire

// File: tb/tb_fifo_thresh.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_thresh
// Description : Randomized and directed bench for fifo_thresh (N=5, W=8).
//               A queue-based reference model predicts the status outputs
//               and the expected pop data. A negedge monitor pops the
//               expected data whenever the DUT presents a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_thresh;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [W-1:0]  push_data;
  logic          pop;
  logic [W-1:0]  pop_data;
  logic          flush;
  logic [CW-1:0] af_thresh;
  logic [CW-1:0] ae_thresh;
  logic          err_clr;
  logic          empty_r;
  logic          full_r;
  logic [CW-1:0] level_r;
  logic          almost_full_r;
  logic          almost_empty_r;
  logic          overflow_r;
  logic          underflow_r;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] mq[$];     // model FIFO contents
  logic [W-1:0] exp_q[$];  // expected pop data, consumed by the monitor
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  fifo_thresh #(.W(W), .N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .push_data      (push_data),
    .pop            (pop),
    .pop_data       (pop_data),
    .flush          (flush),
    .af_thresh      (af_thresh),
    .ae_thresh      (ae_thresh),
    .err_clr        (err_clr),
    .empty_r        (empty_r),
    .full_r         (full_r),
    .level_r        (level_r),
    .almost_full_r  (almost_full_r),
    .almost_empty_r (almost_empty_r),
    .overflow_r     (overflow_r),
    .underflow_r    (underflow_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: whenever the DUT accepts a pop, compare the head with the model.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (!rst && pop && !empty_r && !flush) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_data: got %02h with no entry expected at %0t", pop_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", int'(pop_data), int'(e));
      end
    end
  end

  // One clock cycle: drive the inputs, advance the model, then check status.
  task automatic cyc(input bit p, input logic [W-1:0] d, input bit o,
                     input bit f, input bit c, input bit r);
    int sz;
    bit mfull, mempty;
    push = p; push_data = d; pop = o; flush = f; err_clr = c; rst = r;
    sz     = mq.size();
    mempty = (sz == 0);
    mfull  = (sz == N);
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = (p && mfull && !o && !f) || (m_ovf && !c);
      m_unf = (o && mempty && !f) || (m_unf && !c);
      if (f) mq.delete();
      else begin
        if (o && !mempty) exp_q.push_back(mq.pop_front());
        if (p && (!mfull || o)) mq.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    sz = mq.size();
    chk("level_r",        int'(level_r),        sz);
    chk("empty_r",        int'(empty_r),        int'(sz == 0));
    chk("full_r",         int'(full_r),         int'(sz == N));
    chk("almost_full_r",  int'(almost_full_r),  r ? 0 : int'(sz >= int'(af_thresh)));
    chk("almost_empty_r", int'(almost_empty_r), r ? 1 : int'(sz <= int'(ae_thresh)));
    chk("overflow_r",     int'(overflow_r),     int'(m_ovf));
    chk("underflow_r",    int'(underflow_r),    int'(m_unf));
  endtask

  initial begin
    int bias;
    bit p, o, f, c, r;
    af_thresh = 3'd4;
    ae_thresh = 3'd1;

    // Reset state
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);

    // Fill 0x10..0x14, then drain in order
    for (int i = 0; i < 5; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0, 0);

    // Wrap: 13 interleaved push/pop pairs across several pointer wraps
    cyc(1, 8'h30, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) cyc(1, 8'h31 + 8'(i), 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 5; i++) cyc(1, 8'h20 + 8'(i), 0, 0, 0, 0);
    cyc(1, 8'hAA, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0, 0);

    // Overflow, clear, set-beats-clear, then underflow
    for (int i = 0; i < 5; i++) cyc(1, 8'h40 + 8'(i), 0, 0, 0, 0);
    cyc(1, 8'hEE, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    cyc(1, 8'hEF, 0, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);

    // Flush at level 3 with a push; the underflow flag must survive
    for (int i = 0; i < 3; i++) cyc(1, 8'h60 + 8'(i), 0, 0, 0, 0);
    cyc(1, 8'h77, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    cyc(1, 8'h88, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);

    // Reset at level 4, then new data only
    for (int i = 0; i < 4; i++) cyc(1, 8'h50 + 8'(i), 0, 0, 0, 0);
    cyc(1, 8'h5F, 0, 0, 0, 1);
    cyc(1, 8'h99, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);

    // Randomized traffic with shifting push bias and threshold changes
    for (int k = 0; k < 3000; k++) begin
      bias = ((k / 200) % 2 == 0) ? 70 : 35;
      if ($urandom_range(0, 49) == 0) af_thresh = CW'($urandom_range(1, N));
      if ($urandom_range(0, 49) == 0) ae_thresh = CW'($urandom_range(0, N - 1));
      p = ($urandom_range(0, 99) < bias);
      o = ($urandom_range(0, 99) < (100 - bias));
      f = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 299) == 0);
      cyc(p, W'($urandom), o, f, c, r);
    end
    cyc(0, 8'h00, 0, 0, 0, 0);

    chk("exp_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
